puf_crp_collector: RTL and testbench

Consumer end of the arbiter-PUF challenge path. It steps the challenge LFSR one challenge at a time and fires the PUF arbiter. It then waits for the race to settle, samples the synchronised response bit, and packs RESP_W successive bits into a word. Each word goes out to the readout logic over a valid/ready handshake until the requested number of words has been delivered.

---
 rtl/puf_pkg.sv | 21 ++
 rtl/puf_resp_sync.sv | 21 ++
 rtl/puf_crp_collector.sv | 175 +++++++++++++++++
 tb/tb_puf_crp_collector.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared types and default sizing for the arbiter-PUF challenge/response collector.
package puf_pkg;

  localparam int unsigned PUF_CHAL_W     = 8;
  localparam int unsigned PUF_RESP_W     = 32;
  localparam int unsigned PUF_SETTLE_CYC = 4;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    SETTLE,
    SAMPLE,
    EMIT
  } puf_crp_state_t;

  // 2-of-3 vote across repeated evaluations of one challenge
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/puf_resp_sync.sv
// Two-flop synchroniser bringing the asynchronous arbiter output into the clk domain.
module puf_resp_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/puf_crp_collector.sv
// Arbiter-PUF CRP collector: launches challenges, samples settled responses and packs them
// into words for a valid/ready readout. Define PUF_CRP_MAJ_EN for 3-evaluation majority voting.
module puf_crp_collector
  import puf_pkg::*;
#(
  parameter int unsigned CHAL_W     = PUF_CHAL_W,
  parameter int unsigned RESP_W     = PUF_RESP_W,
  parameter int unsigned SETTLE_CYC = PUF_SETTLE_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       num_words,
  input  logic [CHAL_W-1:0] challenge_in,
  input  logic              puf_resp,
  output logic              lfsr_step,
  output logic              puf_trigger,
  output logic [CHAL_W-1:0] chal_q,
  output logic [RESP_W-1:0] resp_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BIT_W  = $clog2(RESP_W + 1);
  localparam int unsigned SET_W  = $clog2(SETTLE_CYC + 1);
  localparam int unsigned WCNT_W = 16;

  puf_crp_state_t    state, next_state;
  logic [WCNT_W-1:0] words_left, words_left_d;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_d;
  logic [SET_W-1:0]  settle_cnt, settle_cnt_d;
  logic [RESP_W-1:0] data_d;
  logic [CHAL_W-1:0] chal_d;
  logic              done_d;
  logic              resp_sync;
  logic              last_eval_c;
  logic              new_bit_c;

  puf_resp_sync u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (puf_resp),
    .q    (resp_sync)
  );

`ifdef PUF_CRP_MAJ_EN
  logic [1:0] rep, rep_d;
  logic [1:0] votes, votes_d;

  // Only the third evaluation of a challenge produces a packed bit
  assign last_eval_c = (rep == 2'd2);
  assign new_bit_c   = maj3(votes[0], votes[1], resp_sync);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep   <= '0;
      votes <= '0;
    end else begin
      rep   <= rep_d;
      votes <= votes_d;
    end
  end
`else
  assign last_eval_c = 1'b1;
  assign new_bit_c   = resp_sync;
`endif

  // Next-state and datapath update
  always_comb begin
    next_state   = state;
    words_left_d = words_left;
    bit_cnt_d    = bit_cnt;
    settle_cnt_d = settle_cnt;
    data_d       = resp_data;
    chal_d       = chal_q;
    done_d       = 1'b0;
`ifdef PUF_CRP_MAJ_EN
    rep_d        = rep;
    votes_d      = votes;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          if (num_words == '0) begin
            done_d = 1'b1;
          end else begin
            next_state   = LAUNCH;
            words_left_d = num_words;
            bit_cnt_d    = '0;
            data_d       = '0;
`ifdef PUF_CRP_MAJ_EN
            rep_d        = '0;
`endif
          end
        end
      end
      LAUNCH: begin
        chal_d       = challenge_in;
        settle_cnt_d = '0;
        next_state   = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
          next_state = SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt + 1'b1;
        end
      end
      SAMPLE: begin
        next_state = LAUNCH;
        if (last_eval_c) begin
          // Right shift in at the MSB: first challenge's bit lands in bit 0
          data_d    = {new_bit_c, resp_data[RESP_W-1:1]};
          bit_cnt_d = bit_cnt + 1'b1;
          if (bit_cnt_d == BIT_W'(RESP_W)) begin
            next_state = EMIT;
          end
        end
`ifdef PUF_CRP_MAJ_EN
        if (last_eval_c) begin
          rep_d = '0;
        end else begin
          votes_d[rep[0]] = resp_sync;
          rep_d           = rep + 2'd1;
        end
`endif
      end
      EMIT: begin
        if (resp_ready) begin
          words_left_d = words_left - 1'b1;
          bit_cnt_d    = '0;
          if (words_left == WCNT_W'(1)) begin
            done_d     = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = LAUNCH;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State, counters and registered outputs (decoded from the next state)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      words_left  <= '0;
      bit_cnt     <= '0;
      settle_cnt  <= '0;
      resp_data   <= '0;
      chal_q      <= '0;
      puf_trigger <= 1'b0;
      lfsr_step   <= 1'b0;
      resp_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= next_state;
      words_left  <= words_left_d;
      bit_cnt     <= bit_cnt_d;
      settle_cnt  <= settle_cnt_d;
      resp_data   <= data_d;
      chal_q      <= chal_d;
      puf_trigger <= (next_state == LAUNCH);
      lfsr_step   <= (next_state == SAMPLE) && last_eval_c;
      resp_valid  <= (next_state == EMIT);
      busy        <= (next_state != IDLE);
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_puf_crp_collector.sv
// Bench for puf_crp_collector: timeline model of triggers/steps/words against the DUT each cycle.
// Build with PUF_CRP_MAJ_EN defined to exercise the majority-vote variant.
module tb_puf_crp_collector;

  localparam int unsigned CHAL_W     = 8;
  localparam int unsigned RESP_W     = 4;
  localparam int unsigned SETTLE_CYC = 3;
`ifdef PUF_CRP_MAJ_EN
  localparam int EVALS     = 3;
  localparam int LIT_VALID = 61;
  localparam int LIT_DONE2 = 133;
  localparam int LIT_TRIG  = 12;
`else
  localparam int EVALS     = 1;
  localparam int LIT_VALID = 21;
  localparam int LIT_DONE2 = 53;
  localparam int LIT_TRIG  = 4;
`endif
  localparam int EVAL_P = SETTLE_CYC + 2;
  localparam int BIT_P  = EVALS * EVAL_P;
  localparam int WORD_P = RESP_W * BIT_P;
  localparam int NEVAL  = RESP_W * EVALS;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [15:0]       num_words = '0;
  logic [CHAL_W-1:0] challenge_in = 8'h5A;
  logic              puf_resp = 1'b0;
  logic              lfsr_step, puf_trigger, resp_valid, busy, done;
  logic [CHAL_W-1:0] chal_q;
  logic [RESP_W-1:0] resp_data;
  logic              resp_ready = 1'b0;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Model state
  bit                run = 1'b0;
  int                base = 0;
  int                words_left = 0;
  int                done_due = -1;
  logic [RESP_W-1:0] exp_data = '0;
  logic [CHAL_W-1:0] exp_chal = '0;
  bit                evals[NEVAL];

  // Stimulus control shared with the main sequence
  bit pend_start = 1'b0;
  int pend_num   = 0;
  int rst_hold   = 3;
  int ready_mode = 0;
  int hold_until = -1;
  bit resp_mode  = 1'b0;
  bit pat[12];

  // Per-run DUT observations for the literal checks
  int                obs_trig = 0, obs_step = 0, obs_first_valid = -1, obs_done = -1, start_cyc = 0;
  logic [RESP_W-1:0] obs_word = '0;

  puf_crp_collector #(
    .CHAL_W    (CHAL_W),
    .RESP_W    (RESP_W),
    .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_words   (num_words),
    .challenge_in(challenge_in),
    .puf_resp    (puf_resp),
    .lfsr_step   (lfsr_step),
    .puf_trigger (puf_trigger),
    .chal_q      (chal_q),
    .resp_data   (resp_data),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [CHAL_W-1:0] lfsr_next(input logic [CHAL_W-1:0] c);
    return {c[CHAL_W-2:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
  endfunction

  // Model, per-cycle compare and input driving; all on the falling edge
  initial begin : model_cmp
    int   o, idx, ones;
    bit   e_trig, e_step, e_valid, e_busy, e_done, was_run, v;
    logic [RESP_W-1:0] word;
    forever begin
      @(negedge clk);
      e_trig = 1'b0; e_step = 1'b0; e_valid = 1'b0; e_busy = run; o = 0;
      if (run) begin
        o = cyc - base;
        if (o < WORD_P) begin
          e_trig = (o % EVAL_P) == 0;
          e_step = (o % BIT_P) == BIT_P - 1;
        end else begin
          e_valid = 1'b1;
        end
      end
      e_done = (cyc == done_due);
      if (e_valid) begin
        word = '0;
        for (int i = 0; i < RESP_W; i++) begin
          ones = 0;
          for (int k = 0; k < EVALS; k++) ones += int'(evals[i*EVALS+k]);
          word[i] = (2 * ones > EVALS);
        end
        exp_data = word;
      end
      chk("puf_trigger", 64'(puf_trigger), 64'(e_trig));
      chk("lfsr_step", 64'(lfsr_step), 64'(e_step));
      chk("resp_valid", 64'(resp_valid), 64'(e_valid));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("done", 64'(done), 64'(e_done));
      chk("chal_q", 64'(chal_q), 64'(exp_chal));
      if (!run || e_valid) chk("resp_data", 64'(resp_data), 64'(exp_data));

      if (puf_trigger) obs_trig++;
      if (lfsr_step) obs_step++;
      if (resp_valid && obs_first_valid < 0) begin
        obs_first_valid = cyc - start_cyc;
        obs_word        = resp_data;
      end
      if (done) obs_done = cyc - start_cyc;

      was_run = run;
      if (start) start = 1'b0;
      if (pend_start) begin
        start      = 1'b1;
        num_words  = 16'(pend_num);
        pend_start = 1'b0;
        if (!was_run) begin
          start_cyc = cyc; obs_trig = 0; obs_step = 0; obs_first_valid = -1; obs_done = -1;
          hold_until = -1;
          if (pend_num == 0) done_due = cyc + 1;
          else begin
            run = 1'b1; base = cyc + 1; words_left = pend_num;
          end
        end
      end

      if (e_trig) begin
        idx        = o / EVAL_P;
        v          = resp_mode ? pat[idx] : 1'($urandom);
        evals[idx] = v;
        puf_resp   = v;
        exp_chal   = challenge_in;
      end
      if (e_step) challenge_in = lfsr_next(challenge_in);

      case (ready_mode)
        0: resp_ready = 1'b1;
        1: resp_ready = 1'($urandom);
        default: begin
          if (e_valid && hold_until < 0) hold_until = cyc + 10;
          resp_ready = (hold_until >= 0) && (cyc >= hold_until);
        end
      endcase
      if (was_run && e_valid && resp_ready) begin
        words_left--;
        if (words_left == 0) begin
          run      = 1'b0;
          done_due = cyc + 1;
        end else begin
          base = cyc + 1;
        end
      end

      if (rst_hold > 0) begin
        reset = 1'b0; rst_hold--;
        run = 1'b0; done_due = -1; exp_data = '0; exp_chal = '0; start = 1'b0;
      end else begin
        reset = 1'b1;
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while ((pend_start || run) && n < budget);
    if (n >= budget) begin
      compared++;
      mismatched++;
      $display("FAIL wait_idle: run still active after %0d cycles", n);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic run_req(input int n, input int budget);
    pend_num   = n;
    pend_start = 1'b1;
    wait_idle(budget);
  endtask

  task automatic all_ones_run(input string tag);
    pat = '{default: 1'b1};
    resp_mode  = 1'b1;
    ready_mode = 0;
    run_req(1, 400);
    chk({tag, "_first_valid"}, 64'(obs_first_valid), 64'(LIT_VALID));
    chk({tag, "_word"}, 64'(obs_word), 64'(4'hF));
    chk({tag, "_done"}, 64'(obs_done), 64'(LIT_VALID + 1));
    chk({tag, "_trig_cnt"}, 64'(obs_trig), 64'(LIT_TRIG));
    chk({tag, "_step_cnt"}, 64'(obs_step), 64'(4));
  endtask

  initial begin : main
    repeat (6) @(posedge clk);

    all_ones_run("ones");

`ifdef PUF_CRP_MAJ_EN
    pat = '{1, 0, 1, 0, 0, 1, 1, 1, 0, 1, 0, 1};
`else
    pat = '{1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
    resp_mode = 1'b1;
    run_req(1, 400);
    chk("pattern_word", 64'(obs_word), 64'(4'hD));

    // Two words with a 10-cycle stall on the first, plus a start while busy
    resp_mode  = 1'b0;
    ready_mode = 2;
    pend_num   = 2;
    pend_start = 1'b1;
    repeat (10) @(posedge clk);
    pend_num   = 7;
    pend_start = 1'b1;
    wait_idle(800);
    chk("stall_done", 64'(obs_done), 64'(LIT_DONE2));

    ready_mode = 0;
    run_req(0, 40);
    chk("zero_done", 64'(obs_done), 64'(1));
    chk("zero_trig_cnt", 64'(obs_trig), 64'(0));

    ready_mode = 1;
    for (int r = 0; r < 4; r++) run_req(1 + int'($urandom_range(2)), 3000);

    // Abort mid-SETTLE, then a fresh run must match the power-up run
    ready_mode = 0;
    pend_num   = 2;
    pend_start = 1'b1;
    repeat (4) @(posedge clk);
    rst_hold = 2;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_resp_data", 64'(resp_data), 64'(0));
    chk("abort_chal_q", 64'(chal_q), 64'(0));
    all_ones_run("after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
